// File: rtl/logic_gates_pkg.sv
// Shared opcode encoding for the logic_gates bank and its gate evaluator.
package logic_gates_pkg;

   localparam int unsigned GATE_OP_W = 3;

   typedef enum logic [GATE_OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NOT  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_BUF  = 3'd7
   } gate_op_e;

endpackage

// File: rtl/logic_gates_gate_eval.sv
// Combinational bitwise evaluator: one WIDTH-bit result of a two-input logic
// function selected by op.
module logic_gates_gate_eval
   import logic_gates_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [GATE_OP_W-1:0] op,
   output logic [WIDTH-1:0]     result
);

   always_comb begin
      result = a;
      case (gate_op_e'(op))
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_NOT:  result = ~a;
         OP_NAND: result = ~(a & b);
         OP_NOR:  result = ~(a | b);
         OP_XOR:  result = a ^ b;
         OP_XNOR: result = ~(a ^ b);
         OP_BUF:  result = a;
         default: result = a;
      endcase
   end

endmodule

// File: rtl/logic_gates.sv
// Registered bank of the basic bitwise logic functions plus an opcode-selected
// result y; one-cycle latency, synchronous active-high reset.
module logic_gates
   import logic_gates_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [GATE_OP_W-1:0] op_sel,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     and_gate,
   output logic [WIDTH-1:0]     or_gate,
   output logic [WIDTH-1:0]     not_gate,
   output logic [WIDTH-1:0]     nand_gate,
   output logic [WIDTH-1:0]     nor_gate,
   output logic [WIDTH-1:0]     xor_gate,
   output logic [WIDTH-1:0]     xnor_gate,
   output logic [WIDTH-1:0]     y
);

   logic [WIDTH-1:0] and_d, or_d, not_d, nand_d, nor_d, xor_d, xnor_d, y_d;
   logic [WIDTH-1:0] and_q, or_q, not_q, nand_q, nor_q, xor_q, xnor_q, y_q;
   logic             valid_q;

   logic_gates_gate_eval #(.WIDTH(WIDTH)) u_and (
      .a(a), .b(b), .op(OP_AND), .result(and_d)
   );
   logic_gates_gate_eval #(.WIDTH(WIDTH)) u_or (
      .a(a), .b(b), .op(OP_OR), .result(or_d)
   );
   logic_gates_gate_eval #(.WIDTH(WIDTH)) u_not (
      .a(a), .b(b), .op(OP_NOT), .result(not_d)
   );
   logic_gates_gate_eval #(.WIDTH(WIDTH)) u_nand (
      .a(a), .b(b), .op(OP_NAND), .result(nand_d)
   );
   logic_gates_gate_eval #(.WIDTH(WIDTH)) u_nor (
      .a(a), .b(b), .op(OP_NOR), .result(nor_d)
   );
   logic_gates_gate_eval #(.WIDTH(WIDTH)) u_xor (
      .a(a), .b(b), .op(OP_XOR), .result(xor_d)
   );
   logic_gates_gate_eval #(.WIDTH(WIDTH)) u_xnor (
      .a(a), .b(b), .op(OP_XNOR), .result(xnor_d)
   );
   logic_gates_gate_eval #(.WIDTH(WIDTH)) u_sel (
      .a(a), .b(b), .op(op_sel), .result(y_d)
   );

   // Reset clears every result to zero, including the inverting ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         and_q   <= '0;
         or_q    <= '0;
         not_q   <= '0;
         nand_q  <= '0;
         nor_q   <= '0;
         xor_q   <= '0;
         xnor_q  <= '0;
         y_q     <= '0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            and_q  <= and_d;
            or_q   <= or_d;
            not_q  <= not_d;
            nand_q <= nand_d;
            nor_q  <= nor_d;
            xor_q  <= xor_d;
            xnor_q <= xnor_d;
            y_q    <= y_d;
         end
      end
   end

   assign out_valid = valid_q;
   assign and_gate  = and_q;
   assign or_gate   = or_q;
   assign not_gate  = not_q;
   assign nand_gate = nand_q;
   assign nor_gate  = nor_q;
   assign xor_gate  = xor_q;
   assign xnor_gate = xnor_q;
   assign y         = y_q;

endmodule

// File: tb/tb_logic_gates.sv
// Self-checking bench for logic_gates: WIDTH=1 truth table and WIDTH=8 selector,
// reset and randomised checks against a reference model.
module tb_logic_gates;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [2:0] op_sel;
   logic       a1, b1;
   logic [7:0] a8, b8;

   logic       v1, and1, or1, not1, nand1, nor1, xor1, xnor1, y1;
   logic       v8;
   logic [7:0] and8, or8, not8, nand8, nor8, xor8, xnor8, y8;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   logic_gates #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .op_sel(op_sel),
      .out_valid(v1), .and_gate(and1), .or_gate(or1), .not_gate(not1),
      .nand_gate(nand1), .nor_gate(nor1), .xor_gate(xor1), .xnor_gate(xnor1), .y(y1)
   );

   logic_gates #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8), .op_sel(op_sel),
      .out_valid(v8), .and_gate(and8), .or_gate(or8), .not_gate(not8),
      .nand_gate(nand8), .nor_gate(nor8), .xor_gate(xor8), .xnor_gate(xnor8), .y(y8)
   );

   typedef struct {
      logic       a;
      logic       b;
      logic [2:0] op;
      logic [6:0] exp;   // {and, or, not, nand, nor, xor, xnor}
      logic       exp_y;
   } tt_vec_t;

   typedef struct {
      logic [2:0] op;
      logic [7:0] exp_y;
   } sel_vec_t;

   tt_vec_t  tt[4];
   sel_vec_t sv[8];

   // Reference model state for the WIDTH=8 instance.
   logic       m_v;
   logic [7:0] m_and, m_or, m_not, m_nand, m_nor, m_xor, m_xnor, m_y;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return ~a;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return a ^ b;
         3'd6:    return ~(a ^ b);
         default: return a;
      endcase
   endfunction

   function automatic logic [79:0] pack8();
      return {7'd0, v8, and8, or8, not8, nand8, nor8, xor8, xnor8, y8};
   endfunction

   function automatic logic [79:0] pack_model();
      return {7'd0, m_v, m_and, m_or, m_not, m_nand, m_nor, m_xor, m_xnor, m_y};
   endfunction

   initial begin
      tt[0] = '{a: 1'b0, b: 1'b0, op: 3'd0, exp: 7'b0011101, exp_y: 1'b0};
      tt[1] = '{a: 1'b0, b: 1'b1, op: 3'd1, exp: 7'b0111010, exp_y: 1'b1};
      tt[2] = '{a: 1'b1, b: 1'b0, op: 3'd2, exp: 7'b0101010, exp_y: 1'b0};
      tt[3] = '{a: 1'b1, b: 1'b1, op: 3'd3, exp: 7'b1100001, exp_y: 1'b0};
      sv[0] = '{op: 3'd0, exp_y: 8'h42};
      sv[1] = '{op: 3'd1, exp_y: 8'hDB};
      sv[2] = '{op: 3'd2, exp_y: 8'h3C};
      sv[3] = '{op: 3'd3, exp_y: 8'hBD};
      sv[4] = '{op: 3'd4, exp_y: 8'h24};
      sv[5] = '{op: 3'd5, exp_y: 8'h99};
      sv[6] = '{op: 3'd6, exp_y: 8'h66};
      sv[7] = '{op: 3'd7, exp_y: 8'hC3};

      // Reset takes priority over an active input.
      rst = 1'b1; in_valid = 1'b1; op_sel = 3'd3;
      a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      step();
      check("reset_w1", 80'({v1, and1, or1, not1, nand1, nor1, xor1, xnor1, y1}), 80'd0);
      check("reset_w8", pack8(), 80'd0);
      rst = 1'b0; in_valid = 1'b0;
      step();
      step();
      check("post_reset_hold_w1", 80'({v1, and1, or1, not1, nand1, nor1, xor1, xnor1, y1}),
            80'd0);
      check("post_reset_hold_w8", pack8(), 80'd0);

      // Back-to-back truth table at WIDTH=1.
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; a1 = tt[i].a; b1 = tt[i].b; op_sel = tt[i].op;
         step();
         check($sformatf("truth_%0d", i),
               80'({and1, or1, not1, nand1, nor1, xor1, xnor1}), 80'(tt[i].exp));
         check($sformatf("truth_y_%0d", i), 80'(y1), 80'(tt[i].exp_y));
         check($sformatf("truth_valid_%0d", i), 80'(v1), 80'd1);
      end

      // Hold while in_valid is low.
      in_valid = 1'b1; a1 = 1'b1; b1 = 1'b0; op_sel = 3'd5;
      step();
      in_valid = 1'b0; a1 = 1'b0; b1 = 1'b1; op_sel = 3'd0;
      step();
      check("hold_and_or_xor", 80'({and1, or1, xor1}), 80'(3'b011));
      check("hold_y", 80'(y1), 80'd1);
      check("hold_valid", 80'(v1), 80'd0);

      // Selector sweep at WIDTH=8.
      a8 = 8'hC3; b8 = 8'h5A;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; op_sel = sv[i].op;
         step();
         check($sformatf("sel_y_op%0d", i), 80'(y8), 80'(sv[i].exp_y));
      end
      check("sel_dedicated", 80'({and8, or8, not8, nand8, nor8, xor8, xnor8}),
            80'(56'h42DB3CBD249966));

      // Randomised traffic with a one-cycle reset pulse mid-stream.
      m_v = v8; m_and = and8; m_or = or8; m_not = not8; m_nand = nand8;
      m_nor = nor8; m_xor = xor8; m_xnor = xnor8; m_y = 8'hC3;
      for (int c = 0; c < 1000; c++) begin
         in_valid = (c == 500) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
         rst      = (c == 500);
         a8       = 8'($urandom_range(0, 255));
         b8       = 8'($urandom_range(0, 255));
         op_sel   = 3'($urandom_range(0, 7));
         a1       = 1'($urandom_range(0, 1));
         b1       = 1'($urandom_range(0, 1));
         step();
         if (rst) begin
            m_v = 1'b0; m_and = '0; m_or = '0; m_not = '0; m_nand = '0;
            m_nor = '0; m_xor = '0; m_xnor = '0; m_y = '0;
         end else begin
            m_v = in_valid;
            if (in_valid) begin
               m_and  = ref_op(3'd0, a8, b8);
               m_or   = ref_op(3'd1, a8, b8);
               m_not  = ref_op(3'd2, a8, b8);
               m_nand = ref_op(3'd3, a8, b8);
               m_nor  = ref_op(3'd4, a8, b8);
               m_xor  = ref_op(3'd5, a8, b8);
               m_xnor = ref_op(3'd6, a8, b8);
               m_y    = ref_op(op_sel, a8, b8);
            end
         end
         check($sformatf("rand_c%0d", c), pack8(), pack_model());
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
